cosim_vec_seq: RTL and testbench

Self-checking cosim stimulus/response stage that wraps a combinational DUT with packed WIDTH-bit input and output vectors. It drives pseudo-random vectors into the DUT input and folds every DUT output into a multiple-input signature register (MISR). The RTL and the SV symbolic model are compared on the final signature, not vector-by-vector. It sits directly upstream of the DUT `in` port and directly downstream of its `out` port.

---
 rtl/cosim_vec_seq.sv | 99 +++++++++
 tb/tb_cosim_vec_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/cosim_vec_seq.sv
// rtl/cosim_vec_seq.sv - LFSR stimulus driver and MISR response compactor for a combinational DUT.
// Optional stall input enabled by macro COSIM_VEC_SEQ_HOLD_EN.
module cosim_vec_seq #(
  parameter int unsigned       WIDTH  = 128,
  parameter int unsigned       NVEC_W = 16,
  parameter logic [WIDTH-1:0]  SEED   = WIDTH'(1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NVEC_W-1:0] nvec,
`ifdef COSIM_VEC_SEQ_HOLD_EN
  input  logic              hold,
`endif
  output logic [WIDTH-1:0]  dut_in,
  input  logic [WIDTH-1:0]  dut_out,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  signature,
  output logic [NVEC_W-1:0] vec_count
);

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;
  localparam logic [WIDTH-1:0] POLY     = WIDTH'(8'h87);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [NVEC_W-1:0] nvec_lat;
  logic              stall;

  function automatic logic [WIDTH-1:0] mulx(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], 1'b0} ^ (v[WIDTH-1] ? POLY : '0);
  endfunction

`ifdef COSIM_VEC_SEQ_HOLD_EN
  assign stall = hold;
`else
  assign stall = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      dut_in    <= SEED_EFF;
      signature <= '0;
      vec_count <= '0;
      nvec_lat  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            signature <= '0;
            vec_count <= '0;
            if (nvec != '0) begin
              nvec_lat <= nvec;
              dut_in   <= SEED_EFF;
              busy     <= 1'b1;
              state    <= RUN;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        RUN: begin
          // A stalled cycle freezes everything, including the exit decision.
          if (!stall) begin
            signature <= mulx(signature) ^ dut_out;
            dut_in    <= mulx(dut_in);
            vec_count <= vec_count + NVEC_W'(1);
            if (vec_count == nvec_lat - NVEC_W'(1)) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cosim_vec_seq.sv
// tb/tb_cosim_vec_seq.sv - directed self-checking bench for cosim_vec_seq.
// Hold scenario is exercised only when COSIM_VEC_SEQ_HOLD_EN is defined.
module tb_cosim_vec_seq;
  localparam int W  = 128;
  localparam int NW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [NW-1:0] nvec = '0;
  logic          hold = 1'b0;
  logic [W-1:0]  dut_in;
  logic [W-1:0]  dut_out;
  logic          busy;
  logic          done;
  logic [W-1:0]  signature;
  logic [NW-1:0] vec_count;
  logic [1:0]    mode = 2'd1;   // 0: zero response, 1: loopback, 2: unknown

  int errors = 0;
  int checks = 0;
  int n;

  always #5 clk = ~clk;

  assign dut_out = (mode == 2'd1) ? dut_in : (mode == 2'd0) ? '0 : 'x;

  cosim_vec_seq #(.WIDTH(W), .NVEC_W(NW), .SEED(W'(1))) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .nvec(nvec),
`ifdef COSIM_VEC_SEQ_HOLD_EN
    .hold(hold),
`endif
    .dut_in(dut_in),
    .dut_out(dut_out),
    .busy(busy),
    .done(done),
    .signature(signature),
    .vec_count(vec_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    step();
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_sig", signature, W'(0));
    check("rst_cnt", W'(vec_count), W'(0));
    check("rst_din", dut_in, W'(1));
    rst = 1'b0;
    step();

    // nvec = 0 goes straight to DONE
    start = 1'b1; nvec = 0;
    step();
    start = 1'b0;
    check("z_done", W'(done), W'(1));
    check("z_busy", W'(busy), W'(0));
    check("z_sig", signature, W'(0));
    check("z_cnt", W'(vec_count), W'(0));
    step();
    check("z_done_off", W'(done), W'(0));
    check("z_busy_off", W'(busy), W'(0));

    // Loopback, nvec = 1
    mode = 2'd1; start = 1'b1; nvec = 1;
    step();
    start = 1'b0;
    check("n1_busy", W'(busy), W'(1));
    check("n1_din", dut_in, W'(1));
    step();
    check("n1_done", W'(done), W'(1));
    check("n1_busy_off", W'(busy), W'(0));
    check("n1_sig", signature, W'(1));
    check("n1_cnt", W'(vec_count), W'(1));
    check("n1_din_end", dut_in, W'(2));
    step();

    // Loopback, nvec = 3: vectors 1,2,4 ; signatures 1,0,4
    start = 1'b1; nvec = 3;
    step();
    start = 1'b0;
    check("n3_din0", dut_in, W'(1));
    step();
    check("n3_din1", dut_in, W'(2));
    check("n3_sig1", signature, W'(1));
    step();
    check("n3_din2", dut_in, W'(4));
    check("n3_sig2", signature, W'(0));
    step();
    check("n3_done", W'(done), W'(1));
    check("n3_sig", signature, W'(4));
    check("n3_cnt", W'(vec_count), W'(3));
    step();

    // Unknown response outside RUN must not disturb the held signature
    mode = 2'd2;
    step(); step();
    check("x_idle_sig", signature, W'(4));
    check("x_idle_cnt", W'(vec_count), W'(3));

    // Zero response, nvec = 130: x^130 mod P = 0x21C
    mode = 2'd0; start = 1'b1; nvec = 130;
    step();
    start = 1'b0;
    n = 0;
    while (busy && n < 300) begin
      n++;
      step();
    end
    check("n130_cycles", W'(n), W'(130));
    check("n130_done", W'(done), W'(1));
    check("n130_sig", signature, W'(0));
    check("n130_din", dut_in, W'(128'h21C));
    check("n130_cnt", W'(vec_count), W'(130));
    step();

    // Loopback, nvec = 5 with start pulses in RUN and at DONE, nvec changed mid-run
    mode = 2'd1; start = 1'b1; nvec = 5;
    step();
    start = 1'b0;
    step();
    start = 1'b1; nvec = 1;
    step();
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      n++;
      step();
    end
    check("n5_done", W'(done), W'(1));
    check("n5_sig", signature, W'(16));
    check("n5_cnt", W'(vec_count), W'(5));
    start = 1'b1; nvec = 3;
    step();
    start = 1'b0;
    check("n5_restart_busy", W'(busy), W'(0));
    check("n5_restart_done", W'(done), W'(0));
    check("n5_restart_sig", signature, W'(16));
    step();
    check("n5_idle_busy", W'(busy), W'(0));

    // Abort by reset in cycle 2 of a run
    start = 1'b1; nvec = 5;
    step();
    start = 1'b0;
    step();
    check("ab_busy_pre", W'(busy), W'(1));
    rst = 1'b1;
    #1;
    check("ab_busy", W'(busy), W'(0));
    check("ab_sig", signature, W'(0));
    check("ab_cnt", W'(vec_count), W'(0));
    check("ab_din", dut_in, W'(1));
    step();
    rst = 1'b0;
    step();
    check("ab_no_done", W'(done), W'(0));
    check("ab_idle_busy", W'(busy), W'(0));

`ifdef COSIM_VEC_SEQ_HOLD_EN
    // Hold two cycles after the first vector
    start = 1'b1; nvec = 3;
    step();
    start = 1'b0;
    step();
    hold = 1'b1;
    step(); step();
    hold = 1'b0;
    check("h_din_frozen", dut_in, W'(2));
    check("h_sig_frozen", signature, W'(1));
    check("h_busy", W'(busy), W'(1));
    n = 3;
    while (busy && n < 20) begin
      n++;
      step();
    end
    check("h_cycles", W'(n), W'(5));
    check("h_sig", signature, W'(4));
    check("h_cnt", W'(vec_count), W'(3));
    step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
